// File: rtl/fft_unload8.sv
// fft_unload8 -- output-side unloader for the 8-point FFT core.
//
// Captures one parallel 8-bin complex frame per valid/ready handshake into
// one of two ping-pong banks, then replays the frame serially, one complex
// sample per accepted cycle. The core hands over bins in bit-reversed slot
// order; the read side undoes that, so bins leave in natural order 0..7.
// Two banks let the next frame land while the current one drains, which
// sustains one frame every 8 cycles.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   par_val_i       parallel frame valid
//   par_rdy_o       parallel frame ready (registered state only)
//   par_dat_re_i    8 packed real parts, slot j at [(8-j)*DATA_WD-1 -: DATA_WD]
//   par_dat_im_i    8 packed imaginary parts, same packing
//   ser_val_o       serial sample valid
//   ser_rdy_i       serial sample ready (downstream backpressure)
//   ser_dat_re_o    real part of bin ser_idx_o (0 when not valid)
//   ser_dat_im_o    imaginary part of bin ser_idx_o (0 when not valid)
//   ser_idx_o       natural-order bin index
//   ser_last_o      high with ser_val_o on bin 7
module fft_unload8 #(
    parameter int DATA_WD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   par_val_i,
    output logic                   par_rdy_o,
    input  logic [8*DATA_WD-1:0]   par_dat_re_i,
    input  logic [8*DATA_WD-1:0]   par_dat_im_i,
    output logic                   ser_val_o,
    input  logic                   ser_rdy_i,
    output logic [DATA_WD-1:0]     ser_dat_re_o,
    output logic [DATA_WD-1:0]     ser_dat_im_o,
    output logic [2:0]             ser_idx_o,
    output logic                   ser_last_o
);

    logic [DATA_WD-1:0] bank_re [2][8];
    logic [DATA_WD-1:0] bank_im [2][8];
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wr_bank;
    logic               rd_bank;
    logic [2:0]         rd_cnt;
    logic [2:0]         rd_slot;
    logic               wr_fire;
    logic               rd_fire;
    logic               rd_last_fire;

    assign par_rdy_o    = ~full[wr_bank];
    assign ser_val_o    = full[rd_bank];
    assign ser_idx_o    = rd_cnt;
    assign ser_last_o   = ser_val_o & (rd_cnt == 3'd7);

    assign wr_fire      = par_val_i & par_rdy_o;
    assign rd_fire      = ser_val_o & ser_rdy_i;
    assign rd_last_fire = rd_fire & (rd_cnt == 3'd7);

    // Natural bin k lives in slot bitrev3(k).
    assign rd_slot      = {rd_cnt[0], rd_cnt[1], rd_cnt[2]};

    assign ser_dat_re_o = ser_val_o ? bank_re[rd_bank][rd_slot] : '0;
    assign ser_dat_im_o = ser_val_o ? bank_im[rd_bank][rd_slot] : '0;

    // A write can only target an empty bank and a last read only a full one,
    // so when both happen in one edge they always touch different banks.
    always_comb begin
        full_nxt = full;
        if (wr_fire)
            full_nxt[wr_bank] = 1'b1;
        if (rd_last_fire)
            full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 8; j++) begin
                    bank_re[b][j] <= '0;
                    bank_im[b][j] <= '0;
                end
            end
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                for (int j = 0; j < 8; j++) begin
                    bank_re[wr_bank][j] <= par_dat_re_i[(7-j)*DATA_WD +: DATA_WD];
                    bank_im[wr_bank][j] <= par_dat_im_i[(7-j)*DATA_WD +: DATA_WD];
                end
                wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_cnt == 3'd7)
                    rd_bank <= ~rd_bank;
            end
        end
    end

endmodule
